// File: rtl/lift_call_scheduler.sv
// SCAN-order call scheduler sitting in front of the lift movement controller.
// Latches button calls, issues targets with a set strobe, and holds a timed door dwell.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no work in progress; waiting for a latched call
// SELECT | pick the next target in SCAN order, possibly reversing
// ISSUE  | present tgt_floor with a one-cycle tgt_set strobe
// TRAVEL | wait for arrival; retarget if a call appears en route
// DOOR   | door open, dwell down-counter running to terminal count
module lift_call_scheduler #(
    parameter int          NUM_FLOORS = 15,
    parameter int unsigned DOOR_TICKS = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [3:0]            floor,
    output logic [3:0]            tgt_floor,
    output logic                  tgt_set,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up,
    output logic                  busy
);

    localparam logic [31:0] DWELL = 32'(DOOR_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_TRAVEL,
        S_DOOR
    } state_t;

    state_t state, state_nxt;

    logic [NUM_FLOORS-1:0] sync1, sync2, sync3;
    logic [NUM_FLOORS-1:0] rise, tgt_onehot, door_mask, clr_mask;
    logic [31:0]           cnt, cnt_nxt;

    logic       floor_valid, here, up_found, down_found, ahead, arrive;
    logic [3:0] up_tgt, down_tgt, sel_tgt;
    logic       sel_dir, sel_ok;

    assign rise = sync2 & ~sync3;

    // Floor 15 is outside the served range: it never matches a call or an arrival.
    always_comb begin
        floor_valid = (floor < 4'(NUM_FLOORS));
        here        = 1'b0;
        up_found    = 1'b0;
        up_tgt      = 4'd0;
        down_found  = 1'b0;
        down_tgt    = 4'd0;
        ahead       = 1'b0;
        tgt_onehot  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            tgt_onehot[i] = (tgt_floor == 4'(i));
            if (pending[i] && floor_valid && floor == 4'(i))
                here = 1'b1;
            if (pending[i] && 4'(i) < floor) begin
                down_found = 1'b1;
                down_tgt   = 4'(i);
            end
            if (pending[i] && floor_valid &&
                ((tgt_floor > floor && 4'(i) > floor && 4'(i) < tgt_floor) ||
                 (tgt_floor < floor && 4'(i) < floor && 4'(i) > tgt_floor)))
                ahead = 1'b1;
        end
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && 4'(i) > floor) begin
                up_found = 1'b1;
                up_tgt   = 4'(i);
            end
        end
        arrive = floor_valid && (floor == tgt_floor);
    end

    always_comb begin
        sel_tgt = floor;
        sel_dir = dir_up;
        sel_ok  = 1'b1;
        if (here) begin
            sel_tgt = floor;
        end else if (dir_up) begin
            if (up_found) begin
                sel_tgt = up_tgt;
            end else if (down_found) begin
                sel_tgt = down_tgt;
                sel_dir = 1'b0;
            end else begin
                sel_ok = 1'b0;
            end
        end else begin
            if (down_found) begin
                sel_tgt = down_tgt;
            end else if (up_found) begin
                sel_tgt = up_tgt;
                sel_dir = 1'b1;
            end else begin
                sel_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_mask  = '0;
        case (state)
            S_IDLE:   if (|pending) state_nxt = S_SELECT;
            S_SELECT: state_nxt = sel_ok ? S_ISSUE : S_IDLE;
            S_ISSUE:  state_nxt = S_TRAVEL;
            S_TRAVEL: begin
                if (arrive) begin
                    clr_mask  = tgt_onehot;
                    cnt_nxt   = DWELL;
                    state_nxt = S_DOOR;
                end else if (ahead) begin
                    state_nxt = S_SELECT;
                end
            end
            S_DOOR: begin
                cnt_nxt = cnt - 32'd1;
                if (cnt <= 32'd1)
                    state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Calls at the floor whose door is open are absorbed rather than latched.
    assign door_mask = door_open ? tgt_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sync1     <= '0;
            sync2     <= '0;
            sync3     <= '0;
            pending   <= '0;
            tgt_floor <= 4'd0;
            tgt_set   <= 1'b0;
            door_open <= 1'b0;
            dir_up    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sync1     <= call_btn;
            sync2     <= sync1;
            sync3     <= sync2;
            pending   <= (pending | (rise & ~door_mask)) & ~clr_mask;
            if (state == S_SELECT) begin
                dir_up <= sel_dir;
                if (sel_ok)
                    tgt_floor <= sel_tgt;
            end
            tgt_set   <= (state_nxt == S_ISSUE);
            door_open <= (state_nxt == S_DOOR);
            busy      <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: doc/lift_call_scheduler.md
# lift_call_scheduler

Collects floor call requests from push-buttons and sequences them into targets for the lift movement controller. It sits upstream of that controller, driving its target-floor switch bus and set strobe, and watches the controller's current-floor output. Requests are served in SCAN order: keep the current travel direction while calls remain ahead, then reverse. After each arrival it holds a timed door-open dwell.

## Interface
- NUM_FLOORS, 15: floors served, numbered 0..NUM_FLOORS-1; fixed at 15 for a 4-bit floor bus.
- DOOR_TICKS, 100_000_000: door-open dwell in clk cycles (1 s at 100 MHz); minimum 1.
- clk  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- call_btn  in  15  raw call buttons; bit i = call to floor i; asynchronous, level.
- floor  in  4  current floor from the lift controller.
- tgt_floor  out  4  target floor presented to the lift controller's switch input.
- tgt_set  out  1  one-cycle strobe to the lift controller's set input.
- pending  out  15  latched outstanding calls.
- door_open  out  1  high for the dwell at a served floor.
- dir_up  out  1  current scan direction; 1 = up.
- busy  out  1  high in any state other than IDLE.

## Operation
- Input conditioning: call_btn passes through a 2-FF synchronizer, then a third register for edge detection. A rising edge on bit i sets pending[i].
- Clearing: pending[i] clears on the arrival cycle at floor i. While door_open is high at floor i, new edges on bit i are discarded.
  - Same-cycle set and clear on the same bit: the clear wins.
  - All other set events take priority over no-op.
- States:
  - IDLE: if pending != 0, go to SELECT.
  - SELECT (1 cycle): choose the target by these rules, in order, then go to ISSUE.
    - If pending[floor] is set, target = floor.
    - Else if dir_up, target = the lowest pending floor above floor.
    - Else target = the highest pending floor below floor.
    - If none exists in the current direction, toggle dir_up and take the nearest pending floor in the new direction.
  - ISSUE (1 cycle): load tgt_floor, assert tgt_set, go to TRAVEL.
  - TRAVEL: wait for floor == tgt_floor, then clear that pending bit, load the dwell counter, and go to DOOR.
    - Retarget: a pending floor strictly between floor and tgt_floor in the travel direction sends the FSM to SELECT.
  - DOOR: door_open high for exactly DOOR_TICKS cycles, then go to IDLE.
- tgt_floor is held stable from ISSUE until the next ISSUE.
- Floor input value 15 never matches a pending bit and never causes an arrival.
- Widths: dwell counter 32 bits, unsigned floor comparisons, no wrap-around (floor 0 and 14 are hard ends).

## Timing
- Reset values (asynchronous assert, state takes effect immediately):
  - tgt_floor = 0, tgt_set = 0, pending = 0, door_open = 0, dir_up = 1, busy = 0.
  - Synchronizer registers = 0, FSM = IDLE, dwell counter = 0.
- Reset release: first state change no earlier than the first clk edge after rst_n goes high.
- Call latency: call_btn sampled high at edge N sets pending[i] after edge N+2 (bit 0 of edge detect counted). A held button sets the bit only once.
- IDLE-to-strobe latency: with pending first nonzero in IDLE at edge M, SELECT at M+1 and tgt_set high for exactly one cycle after M+2.
- Successive tgt_set pulses are separated by at least 2 low cycles, which guarantees the controller's own edge detector sees each one.
- Arrival-to-door latency: floor == tgt_floor sampled at edge K gives door_open high after K+1 for DOOR_TICKS cycles, then busy low one cycle later if pending == 0.
- Target equal to current floor: TRAVEL detects arrival on the first cycle and enters DOOR without lift motion.
- Reset mid-operation: all state is discarded; pending calls are lost.

## Test plan
Bench settings: DOOR_TICKS=4; lift controller model with a movement interval of 8 cycles; start at floor 0 after reset.
- Reset mid-TRAVEL toward 9 -> all outputs return to their reset values immediately; no tgt_set until a new call.
- Call 5 -> pending=0x0020; tgt_floor=5 with one tgt_set pulse; door_open 4 cycles at floor 5; pending=0.
- Calls 3 and 9 together, lift at 0 -> serve 3 then 9; dir_up stays 1; two tgt_set pulses.
- Lift travelling 0 -> 9, call 4 raised when floor=2 -> retarget: tgt_floor=4 and a new tgt_set; 4 is served before 9.
- Lift at 6 moving up, calls 2 and 8 -> serve 8, dir_up toggles to 0, then serve 2.
- Call 5 pressed while the door is open at 5 -> pending stays 0; call 0 at the same time -> served next.
